// File: rtl/pw_md_stage.sv
// Writeback stage: captures the execute result, runs MUL/DIV through an external
// multicycle unit with start/ready handshake and timeout, and drives the register file.
module pw_md_stage #(
    parameter int DATA_W        = 32,
    parameter int REG_W         = 5,
    parameter int CODE_W        = 8,
    parameter int EXC_REG       = 30,
    parameter int MULT_EXC_CODE = 4,
    parameter int DIV_EXC_CODE  = 5,
    parameter int TO_EXC_CODE   = 6,
    parameter int TIMEOUT       = 64
) (
    input  logic              clock,
    input  logic              clear,
    input  logic [31:0]       ir_in,
    input  logic [DATA_W-1:0] pin,
    input  logic              wen_in,
    input  logic              exc_in,
    input  logic [CODE_W-1:0] exc_code_in,
    input  logic [DATA_W-1:0] md_result,
    input  logic              md_ready,
    input  logic              md_exception,
    output logic              md_start,
    output logic [DATA_W-1:0] p,
    output logic [REG_W-1:0]  rd,
    output logic              we,
    output logic              stall,
    output logic              done
);
    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [4:0] OP_MULT = 5'b00110;
    localparam logic [4:0] OP_DIV  = 5'b00111;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state, state_nx;
    logic [31:0]       ir_q, ir_nx;
    logic [DATA_W-1:0] data_q, data_nx;
    logic              wen_q, wen_nx;
    logic              exc_q, exc_nx;
    logic [CODE_W-1:0] code_q, code_nx;
    logic [CNT_W-1:0]  cnt, cnt_nx;
    logic              start_q, start_nx;
    logic              in_md;

    assign in_md = (ir_in[31:27] == 5'd0) &&
                   ((ir_in[6:2] == OP_MULT) || (ir_in[6:2] == OP_DIV));

    always_comb begin
        state_nx = state;
        ir_nx    = ir_q;
        data_nx  = data_q;
        wen_nx   = wen_q;
        exc_nx   = exc_q;
        code_nx  = code_q;
        cnt_nx   = cnt;
        start_nx = 1'b0;
        case (state)
            IDLE, DONE: begin
                ir_nx   = ir_in;
                data_nx = pin;
                wen_nx  = wen_in;
                code_nx = exc_code_in;
                cnt_nx  = '0;
                if (in_md) begin
                    // exc_in is dropped: the MD unit reports its own exception
                    state_nx = BUSY;
                    start_nx = 1'b1;
                    exc_nx   = 1'b0;
                end else begin
                    state_nx = IDLE;
                    exc_nx   = exc_in;
                end
            end
            BUSY: begin
                if (!start_q && md_ready) begin
                    state_nx = DONE;
                    data_nx  = md_result;
                    exc_nx   = md_exception;
                    code_nx  = (ir_q[6:2] == OP_DIV) ? CODE_W'(DIV_EXC_CODE)
                                                     : CODE_W'(MULT_EXC_CODE);
                end else if (cnt == CNT_LAST) begin
                    state_nx = DONE;
                    exc_nx   = 1'b1;
                    code_nx  = CODE_W'(TO_EXC_CODE);
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state   <= IDLE;
            ir_q    <= '0;
            data_q  <= '0;
            wen_q   <= 1'b0;
            exc_q   <= 1'b0;
            code_q  <= '0;
            cnt     <= '0;
            start_q <= 1'b0;
        end else begin
            state   <= state_nx;
            ir_q    <= ir_nx;
            data_q  <= data_nx;
            wen_q   <= wen_nx;
            exc_q   <= exc_nx;
            code_q  <= code_nx;
            cnt     <= cnt_nx;
            start_q <= start_nx;
        end
    end

    assign md_start = start_q;
    assign stall    = (state == BUSY);
    assign done     = (state == DONE);
    assign p        = exc_q ? DATA_W'(code_q) : data_q;
    assign rd       = exc_q ? REG_W'(EXC_REG) : REG_W'(ir_q[26:22]);
    assign we       = (state != BUSY) & (exc_q | wen_q);

    // instruction fields this stage never looks at
    logic unused_ir_bits;
    assign unused_ir_bits = ^{ir_in[21:7], ir_in[1:0], ir_q[31:27], ir_q[21:7], ir_q[1:0]};
endmodule

// File: tb/tb_pw_md_stage.sv
// Directed bench for pw_md_stage: table of single-cycle vectors plus MD handshake sequences.
module tb_pw_md_stage;
    logic        clk = 1'b0;
    logic        clear;
    logic [31:0] ir_in;
    logic [31:0] pin;
    logic        wen_in;
    logic        exc_in;
    logic [7:0]  exc_code_in;
    logic [31:0] md_result;
    logic        md_ready;
    logic        md_exception;
    logic        md_start;
    logic [31:0] p;
    logic [4:0]  rd;
    logic        we;
    logic        stall;
    logic        done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pw_md_stage dut (
        .clock(clk), .clear(clear), .ir_in(ir_in), .pin(pin), .wen_in(wen_in),
        .exc_in(exc_in), .exc_code_in(exc_code_in), .md_result(md_result),
        .md_ready(md_ready), .md_exception(md_exception), .md_start(md_start),
        .p(p), .rd(rd), .we(we), .stall(stall), .done(done)
    );

    typedef struct {
        logic [31:0] ir;
        logic [31:0] pin;
        logic        wen;
        logic        exc;
        logic [7:0]  code;
        logic [31:0] exp_p;
        logic [4:0]  exp_rd;
        logic        exp_we;
    } vec_t;

    function automatic logic [31:0] mk_ir(input logic [4:0] op, input logic [4:0] r,
                                          input logic [4:0] alu);
        return {op, r, 15'd0, alu, 2'b00};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string name, input logic [31:0] ep, input logic [4:0] erd,
                           input logic ewe, input logic estall, input logic edone);
        chk({name, ".p"}, p, ep);
        chk({name, ".rd"}, 32'(rd), 32'(erd));
        chk({name, ".we"}, 32'(we), 32'(ewe));
        chk({name, ".stall"}, 32'(stall), 32'(estall));
        chk({name, ".done"}, 32'(done), 32'(edone));
    endtask

    // Issue one MD op, pulse md_ready on cycles r0/r1 after capture (cycle 0 = md_start cycle),
    // check stall length, start pulse count and the DONE-cycle outputs; nxt is issued behind it.
    task automatic md_op(input string name, input logic [4:0] alu, input logic [4:0] r,
                         input int r0, input int r1, input logic mexc, input logic [31:0] res,
                         input int exp_stalls, input logic [31:0] ep, input logic [4:0] erd,
                         input logic [31:0] nxt);
        int stalls = 0;
        int starts = 0;
        @(negedge clk);
        ir_in = mk_ir(5'd0, r, alu); pin = 32'hDEAD_BEEF; wen_in = 1'b1;
        exc_in = 1'b1; exc_code_in = 8'h77;
        @(negedge clk);
        ir_in = nxt; pin = 32'h99; wen_in = 1'b1; exc_in = 1'b0; exc_code_in = 8'h0;
        for (int k = 0; k < 200; k++) begin
            if (!stall) break;
            stalls++;
            starts += int'(md_start);
            md_ready = (k == r0) || (k == r1);
            md_exception = mexc;
            md_result = res;
            @(negedge clk);
        end
        md_ready = 1'b0; md_exception = 1'b0;
        chk({name, ".stall_cycles"}, 32'(stalls), 32'(exp_stalls));
        chk({name, ".start_pulses"}, 32'(starts), 32'd1);
        chk_out(name, ep, erd, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
    endtask

    vec_t vecs[5];

    initial begin
        vecs[0] = '{mk_ir(5'd0, 5'd3, 5'd0),  32'h1234,     1'b1, 1'b0, 8'h00, 32'h1234,     5'd3,  1'b1};
        vecs[1] = '{mk_ir(5'd0, 5'd3, 5'd0),  32'h5555,     1'b1, 1'b1, 8'h01, 32'h1,        5'd30, 1'b1};
        vecs[2] = '{mk_ir(5'd1, 5'd9, 5'd6),  32'h55,       1'b0, 1'b0, 8'h00, 32'h55,       5'd9,  1'b0};
        vecs[3] = '{mk_ir(5'd0, 5'd31, 5'd1), 32'hFFFF_FFFF, 1'b0, 1'b0, 8'h00, 32'hFFFF_FFFF, 5'd31, 1'b0};
        vecs[4] = '{mk_ir(5'd2, 5'd4, 5'd7),  32'h42,       1'b0, 1'b1, 8'hFF, 32'hFF,       5'd30, 1'b1};

        clear = 1'b1; ir_in = '0; pin = '0; wen_in = 1'b0; exc_in = 1'b0; exc_code_in = '0;
        md_result = '0; md_ready = 1'b0; md_exception = 1'b0;
        repeat (3) @(negedge clk);
        chk_out("reset", 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
        chk("reset.md_start", 32'(md_start), 32'd0);
        clear = 1'b0;

        foreach (vecs[i]) begin
            ir_in = vecs[i].ir; pin = vecs[i].pin; wen_in = vecs[i].wen;
            exc_in = vecs[i].exc; exc_code_in = vecs[i].code;
            @(negedge clk);
            chk_out($sformatf("vec%0d", i), vecs[i].exp_p, vecs[i].exp_rd, vecs[i].exp_we, 1'b0, 1'b0);
        end

        // normal MUL, ready three cycles after md_start; follow-up ADD captured right after DONE
        md_op("mul_ok", 5'd6, 5'd7, 3, -1, 1'b0, 32'd42, 4, 32'd42, 5'd7, mk_ir(5'd0, 5'd2, 5'd0));
        chk_out("after_mul", 32'h99, 5'd2, 1'b1, 1'b0, 1'b0);
        md_op("div_exc", 5'd7, 5'd9, 2, -1, 1'b1, 32'd11, 3, 32'd5, 5'd30, mk_ir(5'd0, 5'd2, 5'd0));
        md_op("mul_exc", 5'd6, 5'd9, 1, -1, 1'b1, 32'd11, 2, 32'd4, 5'd30, mk_ir(5'd0, 5'd2, 5'd0));
        md_op("timeout", 5'd6, 5'd7, -1, -1, 1'b0, 32'd0, 64, 32'd6, 5'd30, mk_ir(5'd0, 5'd2, 5'd0));
        md_op("ready_at_to", 5'd6, 5'd7, 63, -1, 1'b0, 32'hABC, 64, 32'hABC, 5'd7, mk_ir(5'd0, 5'd2, 5'd0));
        md_op("start_ignored", 5'd7, 5'd5, 0, 2, 1'b0, 32'd13, 3, 32'd13, 5'd5, mk_ir(5'd0, 5'd2, 5'd0));

        // back-to-back: DONE cycle captures a second MUL straight into BUSY
        md_op("b2b_first", 5'd6, 5'd7, 1, -1, 1'b0, 32'd21, 2, 32'd21, 5'd7, mk_ir(5'd0, 5'd8, 5'd6));
        chk("b2b.md_start", 32'(md_start), 32'd1);
        chk("b2b.stall", 32'(stall), 32'd1);
        chk("b2b.we", 32'(we), 32'd0);
        ir_in = mk_ir(5'd0, 5'd0, 5'd0); wen_in = 1'b0; pin = 32'h0;
        @(negedge clk);
        md_ready = 1'b1; md_result = 32'd77;
        @(negedge clk);
        md_ready = 1'b0;
        chk_out("b2b_second", 32'd77, 5'd8, 1'b1, 1'b0, 1'b1);
        @(negedge clk);

        // clear mid-BUSY abandons the op; a late md_ready is ignored
        ir_in = mk_ir(5'd0, 5'd7, 5'd6); wen_in = 1'b1; pin = 32'h1;
        @(negedge clk);
        ir_in = mk_ir(5'd0, 5'd0, 5'd0); wen_in = 1'b0; pin = 32'h0;
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk_out("clear", 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
        chk("clear.md_start", 32'(md_start), 32'd0);
        md_ready = 1'b1; md_result = 32'd55;
        @(negedge clk);
        md_ready = 1'b0;
        chk_out("post_clear", 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
